queue_direction_counter: RTL and testbench
==========================================

Name: queue_direction_counter

Overview:
Sits directly downstream of two debouncer instances. Each debouncer watches one photocell of the queue entrance: sensor A is outside and sensor B is inside. The block consumes their single-cycle rising-edge pulses and decides travel direction from the order of the pulses (A then B is an entry, B then A is an exit). It keeps a saturating occupancy count with full/empty flags, which feeds the display and ticket logic.

Parameters:
MAX_COUNT, 15, occupancy ceiling; count never exceeds this value.
CNT_W, 4, width of count; must satisfy 2^CNT_W > MAX_COUNT.
TIMEOUT, 50000000, cycles allowed between first and second sensor pulse (1 s at 50 MHz).
TO_W, 26, width of the timeout counter; must hold TIMEOUT-1.

Ports:
clk  input  1  system clock; all state on the rising edge.
rst  input  1  reset, asynchronous, active-low (asserted at 0).
a_pulse  input  1  single-cycle pulse from the outer-sensor debouncer.
b_pulse  input  1  single-cycle pulse from the inner-sensor debouncer.
count  output  CNT_W  current occupancy.
full  output  1  high when count == MAX_COUNT.
empty  output  1  high when count == 0.
entry_evt  output  1  one-cycle pulse, valid entry detected.
exit_evt  output  1  one-cycle pulse, valid exit detected.
seq_err  output  1  one-cycle pulse, illegal or timed-out sequence.
ovf  output  1  one-cycle pulse, entry refused at full or exit refused at empty.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timer=0, count=0, empty=1, full=0, all event pulses 0.
- Releasing rst clears nothing further; the first decision is made on the next clk edge.
- FSM states: IDLE, A_SEEN, B_SEEN. All outputs are registered.
- IDLE, a_pulse only: go to A_SEEN, timer=0.
- IDLE, b_pulse only: go to B_SEEN, timer=0.
- IDLE, a_pulse and b_pulse together: stay in IDLE, pulse seq_err.
- A_SEEN, b_pulse (with or without a_pulse): entry complete. Go to IDLE, pulse entry_evt.
- A_SEEN, a_pulse only: re-arm; timer=0, stay in A_SEEN.
- A_SEEN, no pulse and timer==TIMEOUT-1: go to IDLE, pulse seq_err.
- A_SEEN, no pulse otherwise: timer increments.
- B_SEEN: mirror of A_SEEN. a_pulse completes an exit (pulse exit_evt). b_pulse alone re-arms the timer.
- Priority: a completing pulse on the expiry cycle wins over the timeout; seq_err stays 0.
- Latency: entry_evt/exit_evt and the count update appear on the edge that samples the completing pulse.
- Entry with count<MAX_COUNT: count+1.
- Entry with count==MAX_COUNT: count unchanged, entry_evt still pulses, ovf pulses.
- Exit with count>0: count-1.
- Exit with count==0: count unchanged, exit_evt pulses, ovf pulses.
- full and empty are registered and derived from the next value of count, so they are coherent with count in the same cycle.
- At most one of entry_evt, exit_evt, seq_err is high in any cycle. ovf only accompanies entry_evt or exit_evt.
- Reset mid-sequence: the partial sequence is abandoned with no event, and count is cleared.
- The timer runs only in A_SEEN/B_SEEN and holds at 0 in IDLE.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, A_SEEN=2'd1, B_SEEN=2'd2) and the default MAX_COUNT and TIMEOUT constants, for reuse by the display and ticket blocks.
- One sub-module is natural: queue_seq_timer, a TO_W-bit counter.
  - Inputs: clear, enable.
  - Output: expire, asserted when the value is TIMEOUT-1.
- The FSM and the saturating counter stay in the top block.

Test Plan (TIMEOUT=8, MAX_COUNT=3):
- Reset then a_pulse at cycle 2, b_pulse at cycle 5 -> entry_evt=1 at edge 5, count 0->1, empty 1->0; no seq_err.
- From count=1: b_pulse, then a_pulse 3 cycles later -> exit_evt=1, count=0, empty=1.
- a_pulse then nothing for 8 cycles -> seq_err pulse on the 8th cycle after, state IDLE, count unchanged. Also: b_pulse on exactly that 8th cycle -> entry_evt, no seq_err.
- Four complete entries -> count saturates at 3, full=1. 4th entry gives entry_evt with ovf; a following exit at count=0 after draining also gives ovf.
- a_pulse and b_pulse on the same cycle in IDLE -> seq_err only. Then a_pulse, a_pulse 4 cycles later, b_pulse 6 cycles after that -> entry_evt (re-arm prevents the timeout).
- a_pulse, then rst low for 1 cycle, then b_pulse -> no entry_evt, state moves to B_SEEN, count=0.

Source files
------------

// File: rtl/queue_direction_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_direction_counter_pkg
// Description : Shared definitions for the queue entrance direction counter.
//               Holds the direction FSM state encoding and the default
//               occupancy ceiling / sequence timeout, so the display and
//               ticket blocks decode state and limits the same way.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_direction_counter_pkg;

  // Direction FSM state encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEEN = 2'd1,
    B_SEEN = 2'd2
  } qdc_state_e;

  // Default occupancy ceiling
  localparam int c_max_count = 15;
  // Default cycles allowed between first and second pulse (1 s at 50 MHz)
  localparam int c_timeout   = 50000000;

endpackage : queue_direction_counter_pkg
`default_nettype wire

// File: rtl/queue_direction_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : queue_direction_counter_if
// Description : Bundle between the sensor debouncers / display logic and the
//               direction counter.
//   master : drives a_pulse, b_pulse; observes count, flags and events
//   slave  : the counter; consumes the pulses, drives count, full, empty,
//            entry_evt, exit_evt, seq_err, ovf
// Revision    : 1.0 - initial release
// ============================================================================
interface queue_direction_counter_if #(
  parameter int CNT_W = 4
);

  logic             a_pulse;    // outer-sensor rising-edge pulse
  logic             b_pulse;    // inner-sensor rising-edge pulse
  logic [CNT_W-1:0] count;      // current occupancy
  logic             full;       // count == MAX_COUNT
  logic             empty;      // count == 0
  logic             entry_evt;  // one-cycle: entry completed
  logic             exit_evt;   // one-cycle: exit completed
  logic             seq_err;    // one-cycle: illegal or timed-out sequence
  logic             ovf;        // one-cycle: entry at full / exit at empty

  modport master (
    output a_pulse, b_pulse,
    input  count, full, empty, entry_evt, exit_evt, seq_err, ovf
  );

  modport slave (
    input  a_pulse, b_pulse,
    output count, full, empty, entry_evt, exit_evt, seq_err, ovf
  );

endinterface : queue_direction_counter_if
`default_nettype wire

// File: rtl/queue_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : queue_seq_timer
// Description : TO_W-bit sequence timer. Cleared on demand, counts while
//               enabled, and flags expire when it holds TIMEOUT-1.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   clear  : synchronous clear to 0 (wins over enable)
//   enable : increment by one
//   expire : value == TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module queue_seq_timer #(
  parameter int TIMEOUT = 50000000,
  parameter int TO_W    = 26
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expire
);

  localparam logic [TO_W-1:0] c_last = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else if (enable) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign expire = (r_value == c_last);

endmodule : queue_seq_timer
`default_nettype wire

// File: rtl/queue_direction_counter.sv
`default_nettype none
// ============================================================================
// Module      : queue_direction_counter
// Description : Decides travel direction at the queue entrance from the order
//               of the outer (A) and inner (B) sensor pulses and keeps a
//               saturating occupancy count with full/empty flags.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of queue_direction_counter_if
//          (a_pulse, b_pulse in; count, full, empty, entry_evt, exit_evt,
//           seq_err, ovf out - all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module queue_direction_counter
  import queue_direction_counter_pkg::*;
#(
  parameter int MAX_COUNT = c_max_count,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = c_timeout,
  parameter int TO_W      = 26
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  queue_direction_counter_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_COUNT);

  qdc_state_e       r_state;
  qdc_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_entry;
  logic             r_exit;
  logic             r_err;
  logic             r_ovf;
  logic             w_entry;
  logic             w_exit;
  logic             w_err;
  logic             w_ovf;
  logic             w_tmr_clear;
  logic             w_tmr_en;
  logic             w_expire;

  // --------------------------------------------------------------------------
  // Sequence timer: only advances while waiting for the second pulse; every
  // other path (IDLE, arming, re-arming, completion) holds it at zero.
  // --------------------------------------------------------------------------
  queue_seq_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_seq_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_tmr_clear),
    .enable (w_tmr_en),
    .expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // Direction FSM - next state and event decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_entry     = 1'b0;
    w_exit      = 1'b0;
    w_err       = 1'b0;
    w_tmr_clear = 1'b1;
    w_tmr_en    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.a_pulse && bus.b_pulse) begin
          w_err = 1'b1;                       // no order can be inferred
        end else if (bus.a_pulse) begin
          w_state_nxt = A_SEEN;
        end else if (bus.b_pulse) begin
          w_state_nxt = B_SEEN;
        end
      end

      A_SEEN: begin
        // Completing pulse is checked before expiry so it wins on that cycle
        if (bus.b_pulse) begin
          w_entry     = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.a_pulse) begin
          w_state_nxt = A_SEEN;               // re-arm: timer cleared
        end else if (w_expire) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmr_clear = 1'b0;
          w_tmr_en    = 1'b1;
        end
      end

      B_SEEN: begin
        if (bus.a_pulse) begin
          w_exit      = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.b_pulse) begin
          w_state_nxt = B_SEEN;
        end else if (w_expire) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmr_clear = 1'b0;
          w_tmr_en    = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Saturating occupancy update; a refused move still reports its event
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_nxt = r_count;
    w_ovf       = 1'b0;
    if (w_entry) begin
      if (r_count == c_max) begin
        w_ovf = 1'b1;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end else if (w_exit) begin
      if (r_count == '0) begin
        w_ovf = 1'b1;
      end else begin
        w_count_nxt = r_count - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers. Flags come from the next count so they are
  // coherent with count in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_entry <= 1'b0;
      r_exit  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_max);
      r_empty <= (w_count_nxt == '0);
      r_entry <= w_entry;
      r_exit  <= w_exit;
      r_err   <= w_err;
      r_ovf   <= w_ovf;
    end
  end

  assign bus.count     = r_count;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.entry_evt = r_entry;
  assign bus.exit_evt  = r_exit;
  assign bus.seq_err   = r_err;
  assign bus.ovf       = r_ovf;

endmodule : queue_direction_counter
`default_nettype wire

// File: tb/tb_queue_direction_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_direction_counter
// Description : Self-checking bench for queue_direction_counter
//               (MAX_COUNT=3, TIMEOUT=8). The driver applies one input vector
//               per cycle on the falling edge and pushes the expected outputs
//               from a timestamp-based sequence model; the monitor pops and
//               compares one entry shortly after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_direction_counter;

  localparam int MAX_COUNT = 3;
  localparam int CNT_W     = 4;
  localparam int TIMEOUT   = 8;
  localparam int TO_W      = 4;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             entry;
    logic             exit_e;
    logic             err;
    logic             ovf;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  queue_direction_counter_if #(.CNT_W(CNT_W)) bus ();

  queue_direction_counter #(
    .MAX_COUNT (MAX_COUNT),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (TO_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: remembers which sensor fired first and the cycle number
  // of its latest (re-)arming pulse; the timeout is a difference of cycle
  // numbers rather than a running counter.
  int m_first   = 0;   // 0 none, 1 outer first, 2 inner first
  int m_arm_cyc = 0;
  int m_cyc     = 0;
  int m_count   = 0;

  task automatic step(input logic a, input logic b, input logic rn);
    obs_t e;
    @(negedge clk);
    bus.a_pulse = a;
    bus.b_pulse = b;
    rst         = rn;
    e = '0;
    if (!rn) begin
      m_first = 0;
      m_count = 0;
    end else begin
      case (m_first)
        0: begin
          if (a && b) e.err = 1'b1;
          else if (a) begin m_first = 1; m_arm_cyc = m_cyc; end
          else if (b) begin m_first = 2; m_arm_cyc = m_cyc; end
        end
        1: begin
          if (b) begin e.entry = 1'b1; m_first = 0; end
          else if (a) m_arm_cyc = m_cyc;
          else if (m_cyc - m_arm_cyc == TIMEOUT) begin e.err = 1'b1; m_first = 0; end
        end
        default: begin
          if (a) begin e.exit_e = 1'b1; m_first = 0; end
          else if (b) m_arm_cyc = m_cyc;
          else if (m_cyc - m_arm_cyc == TIMEOUT) begin e.err = 1'b1; m_first = 0; end
        end
      endcase
      if (e.entry) begin
        if (m_count == MAX_COUNT) e.ovf = 1'b1;
        else m_count++;
      end
      if (e.exit_e) begin
        if (m_count == 0) e.ovf = 1'b1;
        else m_count--;
      end
    end
    e.count = CNT_W'(m_count);
    e.full  = (m_count == MAX_COUNT);
    e.empty = (m_count == 0);
    m_cyc++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: one observation per cycle, checked against the oldest expectation
  initial begin
    obs_t e;
    obs_t act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act.count  = bus.count;
        act.full   = bus.full;
        act.empty  = bus.empty;
        act.entry  = bus.entry_evt;
        act.exit_e = bus.exit_evt;
        act.err    = bus.seq_err;
        act.ovf    = bus.ovf;
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got cnt=%0d f=%b e=%b ent=%b ex=%b err=%b ovf=%b exp cnt=%0d f=%b e=%b ent=%b ex=%b err=%b ovf=%b",
                   $time, act.count, act.full, act.empty, act.entry, act.exit_e, act.err, act.ovf,
                   e.count, e.full, e.empty, e.entry, e.exit_e, e.err, e.ovf);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    bus.a_pulse = 1'b0;
    bus.b_pulse = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Entry: A then B three cycles later
    step(1'b1, 1'b0, 1'b1); idle(2); step(1'b0, 1'b1, 1'b1);
    // Exit from count=1
    step(1'b0, 1'b1, 1'b1); idle(2); step(1'b1, 1'b0, 1'b1);

    // Timeout after 8 quiet cycles, then completion exactly on expiry cycle
    step(1'b1, 1'b0, 1'b1); idle(TIMEOUT);
    step(1'b1, 1'b0, 1'b1); idle(TIMEOUT - 1); step(1'b0, 1'b1, 1'b1);

    // Saturate at MAX_COUNT, then drain past empty
    for (int i = 0; i < 4; i++) begin step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b1); end
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b1); end

    // Simultaneous pulses in IDLE, then re-arm keeps the sequence alive
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1); idle(3); step(1'b1, 1'b0, 1'b1); idle(5); step(1'b0, 1'b1, 1'b1);

    // Reset mid-sequence abandons it; B afterwards starts an exit sequence
    step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b1);
    idle(TIMEOUT + 1);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 199) != 0));
    end
    idle(2);

    // Bounded drain of the scoreboard
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL compare_count got=%0d required>=12", total);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_queue_direction_counter
`default_nettype wire
